// File: rtl/blowfish_feistel_core.sv
// Blowfish-style Feistel round controller with an external F-function.
// The block holds the L/R halves and sequences ROUNDS rounds of
// key-mix / F-call / swap, then the output whitening, over a handshake.
//
// Ports:
//   Clk, RstN             clock, asynchronous active-low reset
//   in_valid/in_ready     input block handshake; din = {L, R}, decrypt latched on accept
//   skey_ready            subkey array P is valid (gates in_ready)
//   P                     ROUNDS+2 subkeys, P[k] at bits [k*HALF_W +: HALF_W]
//   abort                 synchronous cancel of the block in flight
//   out_valid/out_ready   result handshake; dout = {L, R}, held stable while out_valid
//   X, ffunc_enable       registered F operand and one-cycle request pulse
//   Y, ffunc_ready        F result and its valid strobe (any latency >= 0)
module blowfish_feistel_core #(
  parameter int unsigned HALF_W = 64,
  parameter int unsigned ROUNDS = 16
) (
  input  logic                         Clk,
  input  logic                         RstN,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2*HALF_W-1:0]          din,
  input  logic                         decrypt,
  input  logic                         skey_ready,
  input  logic [(ROUNDS+2)*HALF_W-1:0] P,
  input  logic                         abort,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*HALF_W-1:0]          dout,
  output logic [HALF_W-1:0]            X,
  output logic                         ffunc_enable,
  input  logic [HALF_W-1:0]            Y,
  input  logic                         ffunc_ready
);

  localparam int unsigned RndW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
  localparam int unsigned KeyW = $clog2(ROUNDS + 2);

  typedef enum logic [2:0] {StIdle, StKeymix, StFwait, StFinal, StDone} state_e;

  state_e              state_q;
  logic [HALF_W-1:0]   l_q, r_q, x_q;
  logic [RndW-1:0]     rnd_q;
  logic                dec_q;
  logic [2*HALF_W-1:0] dout_q;
  logic                out_valid_q, fen_q;

  // Subkey selection: decryption walks the P array backwards.
  logic [KeyW-1:0]   km_idx;
  int unsigned       km_base;
  logic [HALF_W-1:0] km_key, fin_r_key, fin_l_key, l_mixed;

  always_comb begin
    km_idx    = dec_q ? (KeyW'(ROUNDS + 1) - KeyW'(rnd_q)) : KeyW'(rnd_q);
    km_base   = 32'(km_idx) * HALF_W;
    km_key    = P[km_base +: HALF_W];
    fin_r_key = dec_q ? P[HALF_W +: HALF_W] : P[ROUNDS*HALF_W +: HALF_W];
    fin_l_key = dec_q ? P[0 +: HALF_W]      : P[(ROUNDS+1)*HALF_W +: HALF_W];
    l_mixed   = l_q ^ km_key;
  end

  assign in_ready     = (state_q == StIdle) && skey_ready;
  assign out_valid    = out_valid_q;
  assign dout         = dout_q;
  assign X            = x_q;
  assign ffunc_enable = fen_q;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q     <= StIdle;
      l_q         <= '0;
      r_q         <= '0;
      x_q         <= '0;
      rnd_q       <= '0;
      dec_q       <= 1'b0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      fen_q       <= 1'b0;
    end else begin
      // The request is a single-cycle pulse; only KEYMIX raises it.
      fen_q <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q     <= StIdle;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (in_valid && skey_ready) begin
              l_q     <= din[2*HALF_W-1:HALF_W];
              r_q     <= din[HALF_W-1:0];
              rnd_q   <= '0;
              dec_q   <= decrypt;
              state_q <= StKeymix;
            end
          end
          StKeymix: begin
            l_q     <= l_mixed;
            x_q     <= l_mixed;
            fen_q   <= 1'b1;
            state_q <= StFwait;
          end
          StFwait: begin
            if (ffunc_ready) begin
              if (rnd_q == RndW'(ROUNDS - 1)) begin
                // Last round leaves the halves unswapped.
                r_q     <= r_q ^ Y;
                state_q <= StFinal;
              end else begin
                l_q     <= r_q ^ Y;
                r_q     <= l_q;
                rnd_q   <= rnd_q + 1'b1;
                state_q <= StKeymix;
              end
            end
          end
          StFinal: begin
            l_q         <= l_q ^ fin_l_key;
            r_q         <= r_q ^ fin_r_key;
            dout_q      <= {l_q ^ fin_l_key, r_q ^ fin_r_key};
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
          StDone: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blowfish_feistel_core.sv
// Self-checking bench for blowfish_feistel_core: a 64/16 instance driven by
// a latency-programmable F stub, and a 32/2 instance for the small key vector.
module tb_blowfish_feistel_core;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready, decrypt, skey_ready, abort;
  logic           out_valid, out_ready, fen, fready;
  logic [127:0]   din, dout;
  logic [63:0]    x_op, y_res;
  logic [18*64-1:0] p_bus;

  logic           in_valid2, in_ready2, decrypt2, out_valid2, out_ready2, fen2;
  logic [63:0]    din2, dout2;
  logic [31:0]    x2;
  logic [4*32-1:0] p_bus2;

  logic [63:0]    pk [18];
  int             dly;
  bit             fmode;
  int             tests = 0;
  int             fails = 0;

  always #5 clk = ~clk;

  blowfish_feistel_core #(.HALF_W(64), .ROUNDS(16)) dut (
    .Clk(clk), .RstN(rst_n), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .decrypt(decrypt), .skey_ready(skey_ready), .P(p_bus), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .X(x_op),
    .ffunc_enable(fen), .Y(y_res), .ffunc_ready(fready)
  );

  blowfish_feistel_core #(.HALF_W(32), .ROUNDS(2)) dut2 (
    .Clk(clk), .RstN(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .din(din2),
    .decrypt(decrypt2), .skey_ready(1'b1), .P(p_bus2), .abort(1'b0),
    .out_valid(out_valid2), .out_ready(out_ready2), .dout(dout2), .X(x2),
    .ffunc_enable(fen2), .Y(32'h0), .ffunc_ready(fen2)
  );

  // F stub: ready arrives dly cycles after the enable cycle (same cycle if dly == 0).
  bit stub_pend;
  int stub_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_pend <= 1'b0;
      stub_cnt  <= 0;
    end else if (abort) begin
      stub_pend <= 1'b0;
    end else if (fen) begin
      stub_pend <= (dly > 0);
      stub_cnt  <= dly - 1;
    end else if (stub_pend) begin
      if (stub_cnt == 0) stub_pend <= 1'b0;
      else stub_cnt <= stub_cnt - 1;
    end
  end
  assign fready = (fen && dly == 0) || (stub_pend && stub_cnt == 0);
  assign y_res  = fmode ? {x_op[55:0], x_op[63:56]} : 64'h0;

  function automatic logic [63:0] fref(input logic [63:0] v);
    return fmode ? {v[55:0], v[63:56]} : 64'h0;
  endfunction

  function automatic logic [63:0] key(input int k, input bit dec);
    return dec ? pk[17 - k] : pk[k];
  endfunction

  // Textbook Blowfish: 16 swapped rounds, undo the final swap, whiten.
  function automatic logic [127:0] model(input logic [127:0] blk, input bit dec);
    logic [63:0] l, r, t;
    l = blk[127:64];
    r = blk[63:0];
    for (int i = 0; i < 16; i++) begin
      l = l ^ key(i, dec);
      r = r ^ fref(l);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ key(16, dec);
    l = l ^ key(17, dec);
    return {l, r};
  endfunction

  task automatic load_keys(input bit zero);
    for (int k = 0; k < 18; k++) begin
      pk[k] = zero ? 64'h0 : {$urandom, $urandom};
      p_bus[k*64 +: 64] = pk[k];
    end
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Returns at the negedge of the KEYMIX cycle that follows the accept.
  task automatic accept(input logic [127:0] d, input bit dec);
    int n;
    @(negedge clk);
    in_valid = 1'b1; din = d; decrypt = dec;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_ready", {127'h0, in_ready}, 128'h1);
    @(negedge clk);
    in_valid = 1'b0; decrypt = ~dec; din = {4{$urandom}};
  endtask

  task automatic run_op(input logic [127:0] d, input bit dec, output logic [127:0] q,
                        output int lat, output int pulses);
    accept(d, dec);
    lat = 1; pulses = 0;
    while (!out_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (fen) pulses++;
    end
    q = dout;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_in_ready", {127'h0, in_ready}, 128'h1);
    check("idle_out_valid", {127'h0, out_valid}, 128'h0);
  endtask

  task automatic wait_pulses(input int n);
    int p, cyc;
    p = 0; cyc = 0;
    while (p < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (fen) p++;
    end
    check("reach_round", 128'(p), 128'(n));
  endtask

  typedef struct {
    logic [127:0] d;
    bit           dec;
    int           lat_d;
    logic [127:0] exp_q;
    int           exp_lat;
  } vec_t;

  vec_t vecs [3];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] q, q2, hold;
    int lat, pulses, n;

    vecs[0] = '{128'h1111111111111111_2222222222222222, 1'b0, 1,
                128'h2222222222222222_1111111111111111, 50};
    vecs[1] = '{128'h0123456789abcdef_fedcba9876543210, 1'b1, 0,
                128'hfedcba9876543210_0123456789abcdef, 34};
    vecs[2] = '{128'hdeadbeefcafef00d_0badc0de12345678, 1'b0, 3,
                128'h0badc0de12345678_deadbeefcafef00d, 82};

    rst_n = 1'b0; in_valid = 0; decrypt = 0; din = '0; skey_ready = 1; abort = 0;
    out_ready = 0; in_valid2 = 0; decrypt2 = 0; din2 = '0; out_ready2 = 0;
    dly = 1; fmode = 0;
    p_bus2 = {32'd8, 32'd4, 32'd2, 32'd1};
    load_keys(1'b1);
    #23;
    check("rst_in_ready", {127'h0, in_ready}, 128'h1);
    check("rst_out_valid", {127'h0, out_valid}, 128'h0);
    check("rst_fen", {127'h0, fen}, 128'h0);
    check("rst_x", {64'h0, x_op}, 128'h0);
    check("rst_dout", dout, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with zero keys and zero F: result is the swapped input.
    for (int i = 0; i < 3; i++) begin
      dly = vecs[i].lat_d;
      run_op(vecs[i].d, vecs[i].dec, q, lat, pulses);
      check($sformatf("vec%0d_dout", i), q, vecs[i].exp_q);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].exp_lat));
      check($sformatf("vec%0d_pulses", i), 128'(pulses), 128'd16);
      release_out();
    end

    // Round trip with F = rotl8, D = 3.
    fmode = 1; dly = 3;
    load_keys(1'b0);
    run_op(128'h123456abcd132536_123456abcd132536, 1'b0, q, lat, pulses);
    check("rt_enc", q, model(128'h123456abcd132536_123456abcd132536, 1'b0));
    check("rt_enc_pulses", 128'(pulses), 128'd16);
    release_out();
    run_op(q, 1'b1, q2, lat, pulses);
    check("rt_dec", q2, 128'h123456abcd132536_123456abcd132536);
    check("rt_dec_pulses", 128'(pulses), 128'd16);
    release_out();

    // Randomized keys, data and F latency.
    for (int i = 0; i < 6; i++) begin
      logic [127:0] d;
      load_keys(1'b0);
      dly = $urandom_range(0, 3);
      d = {$urandom, $urandom, $urandom, $urandom};
      run_op(d, 1'b0, q, lat, pulses);
      check($sformatf("rnd%0d_enc", i), q, model(d, 1'b0));
      check($sformatf("rnd%0d_lat", i), 128'(lat), 128'(16 * (dly + 2) + 2));
      release_out();
      run_op(q, 1'b1, q2, lat, pulses);
      check($sformatf("rnd%0d_dec", i), q2, d);
      release_out();
    end

    // Backpressure: result held while out_ready stays low.
    dly = 2;
    run_op(128'h00ff00ff00ff00ff_a5a5a5a55a5a5a5a, 1'b0, q, lat, pulses);
    hold = model(128'h00ff00ff00ff00ff_a5a5a5a55a5a5a5a, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_dout", dout, hold);
      check("bp_in_ready", {127'h0, in_ready}, 128'h0);
      check("bp_out_valid", {127'h0, out_valid}, 128'h1);
    end
    release_out();

    // Abort during FWAIT of round 5.
    dly = 1;
    accept(128'hfeedfacefeedface_0123012301230123, 1'b0);
    wait_pulses(6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_ready", {127'h0, in_ready}, 128'h1);
    check("abort_out_valid", {127'h0, out_valid}, 128'h0);
    check("abort_fen", {127'h0, fen}, 128'h0);
    n = 0;
    repeat (4) begin @(negedge clk); if (out_valid || fen) n++; end
    check("abort_quiet", 128'(n), 128'd0);
    run_op(128'h0f0f0f0f0f0f0f0f_1234123412341234, 1'b1, q, lat, pulses);
    check("abort_next", q, model(128'h0f0f0f0f0f0f0f0f_1234123412341234, 1'b1));
    release_out();

    // Reset during round 8.
    accept(128'h9999888877776666_5555444433332222, 1'b0);
    wait_pulses(9);
    rst_n = 1'b0;
    #1;
    check("rr_out_valid", {127'h0, out_valid}, 128'h0);
    check("rr_fen", {127'h0, fen}, 128'h0);
    check("rr_x", {64'h0, x_op}, 128'h0);
    check("rr_dout", dout, 128'h0);
    check("rr_in_ready", {127'h0, in_ready}, 128'h1);
    skey_ready = 1'b0;
    #1;
    check("rr_in_ready_nokey", {127'h0, in_ready}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin @(negedge clk); if (out_valid || fen || in_ready) n++; end
    check("rr_quiet", 128'(n), 128'd0);
    skey_ready = 1'b1;
    #1;
    check("rr_in_ready_key", {127'h0, in_ready}, 128'h1);

    // Small instance: HALF_W=32, ROUNDS=2, P = {1,2,4,8}, Y = 0, D = 0.
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      in_valid2 = 1'b1;
      decrypt2  = (pass == 1);
      din2      = (pass == 0) ? 64'h0 : 64'h0000000A_00000005;
      @(negedge clk);
      in_valid2 = 1'b0;
      decrypt2  = (pass == 0);
      lat = 1;
      while (!out_valid2 && lat < 100) begin @(negedge clk); lat++; end
      check($sformatf("small%0d_dout", pass), {64'h0, dout2},
            (pass == 0) ? 128'h0000000A_00000005 : 128'h0);
      check($sformatf("small%0d_lat", pass), 128'(lat), 128'd6);
      out_ready2 = 1'b1;
      @(negedge clk);
      out_ready2 = 1'b0;
      check($sformatf("small%0d_idle", pass), {127'h0, in_ready2}, 128'h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
